// File: rtl/brnch_pred_pkg.sv
// Shared types for the branch-prediction controller: 2-bit counter states,
// the branch history/target table entry layout and the counter transition.
package brnch_pred_pkg;

    // Widths of the stored table entry fields (tag and target address).
    localparam int BP_TAG_W = 8;
    localparam int BP_PC_W  = 32;

    typedef enum logic [1:0] {
        PREDICT_NOT_TAKEN_FIRST  = 2'b00,
        PREDICT_NOT_TAKEN_SECOND = 2'b01,
        PREDICT_TAKEN_SECOND     = 2'b10,
        PREDICT_TAKEN_FIRST      = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        ctr_t                ctr;
        logic [BP_PC_W-1:0]  target;
    } bht_entry_t;

    // Counter transition on a resolved branch. A weakly-not-taken entry
    // jumps straight to strongly taken on a taken outcome.
    function automatic ctr_t next_ctr(input ctr_t cur, input logic taken);
        ctr_t nxt;
        case (cur)
            PREDICT_TAKEN_FIRST:      nxt = taken ? PREDICT_TAKEN_FIRST      : PREDICT_TAKEN_SECOND;
            PREDICT_TAKEN_SECOND:     nxt = taken ? PREDICT_TAKEN_FIRST      : PREDICT_NOT_TAKEN_FIRST;
            PREDICT_NOT_TAKEN_SECOND: nxt = taken ? PREDICT_TAKEN_FIRST      : PREDICT_NOT_TAKEN_FIRST;
            PREDICT_NOT_TAKEN_FIRST:  nxt = taken ? PREDICT_NOT_TAKEN_SECOND : PREDICT_NOT_TAKEN_FIRST;
            default:                  nxt = PREDICT_NOT_TAKEN_FIRST;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/brnch_pred_ctrl_bht_table.sv
// Direct-mapped branch history/target table: one combinational lookup port
// and one synchronous update port that applies the resolved outcome
// (counter step on a tag hit, allocation on a taken miss).
module bht_table
    import brnch_pred_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_W-1:0]    rd_idx,
    output bht_entry_t          rd_entry,
    input  logic                upd_en,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic [BP_TAG_W-1:0] upd_tag,
    input  logic                upd_taken,
    input  logic [BP_PC_W-1:0]  upd_target
);

    localparam int DEPTH = 1 << IDX_W;

    bht_entry_t mem_r [DEPTH];
    bht_entry_t cur_s;
    bht_entry_t nxt_s;
    logic       wr_en_s;

    assign rd_entry = mem_r[rd_idx];
    assign cur_s    = mem_r[upd_idx];

    // Build the replacement entry for the resolving branch's slot.
    always_comb begin
        nxt_s   = cur_s;
        wr_en_s = 1'b0;
        if (upd_en) begin
            if (cur_s.valid && (cur_s.tag == upd_tag)) begin
                wr_en_s   = 1'b1;
                nxt_s.ctr = next_ctr(cur_s.ctr, upd_taken);
                if (upd_taken) begin
                    nxt_s.target = upd_target;
                end else begin
                    nxt_s.target = cur_s.target;
                end
            end else if (upd_taken) begin
                wr_en_s      = 1'b1;
                nxt_s.valid  = 1'b1;
                nxt_s.tag    = upd_tag;
                nxt_s.ctr    = PREDICT_TAKEN_SECOND;
                nxt_s.target = upd_target;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table storage; reset invalidates every entry and clears its counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i].valid <= 1'b0;
                mem_r[i].ctr   <= PREDICT_NOT_TAKEN_FIRST;
            end
        end else if (wr_en_s) begin
            mem_r[upd_idx] <= nxt_s;
        end
    end

endmodule

// File: rtl/brnch_pred_ctrl.sv
// Branch-prediction controller: IF-stage table lookup, IF/ID prediction
// record, ID-stage resolution with flush/redirect, and statistics counters.
module brnch_pred_ctrl
    import brnch_pred_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 8,
    parameter int PC_W   = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              brch_instr_detectd_IF,
    input  logic              if_stall,
    input  logic              brch_instr_detectd_ID,
    input  logic              brch_hazard_stall,
    input  logic              actual_brch_result,
    input  logic [PC_W-1:0]   actual_target,
    output logic              predict_br_taken,
    output logic [PC_W-1:0]   predict_target,
    output logic              mispredict_flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_br_cnt,
    output logic [STAT_W-1:0] stat_mispred_cnt
);

    logic [IDX_W-1:0] if_idx_s;
    logic [TAG_W-1:0] if_tag_s;
    bht_entry_t       rd_entry_s;
    logic             hit_s;
    logic             ctr_taken_s;
    logic             resolve_s;
    logic [TAG_W-1:0] rec_tag_s;

    logic             rec_valid_r;
    logic [PC_W-1:0]  rec_pc_r;
    logic [IDX_W-1:0] rec_idx_r;
    logic             rec_pred_r;
    logic [PC_W-1:0]  rec_tgt_r;

    assign if_idx_s  = if_pc[IDX_W+1:2];
    assign if_tag_s  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign rec_tag_s = rec_pc_r[IDX_W+TAG_W+1:IDX_W+2];

    // The update port sees the entry as it was before this edge, so a
    // same-index lookup in the resolve cycle returns pre-update data.
    bht_table #(.IDX_W(IDX_W)) u_bht_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (if_idx_s),
        .rd_entry   (rd_entry_s),
        .upd_en     (resolve_s),
        .upd_idx    (rec_idx_r),
        .upd_tag    (rec_tag_s),
        .upd_taken  (actual_brch_result),
        .upd_target (actual_target)
    );

    assign hit_s       = rd_entry_s.valid && (rd_entry_s.tag == if_tag_s);
    assign ctr_taken_s = (rd_entry_s.ctr == PREDICT_TAKEN_FIRST) ||
                         (rd_entry_s.ctr == PREDICT_TAKEN_SECOND);

    assign predict_br_taken = brch_instr_detectd_IF && hit_s && ctr_taken_s;
    assign predict_target   = predict_br_taken ? rd_entry_s.target : {PC_W{1'b0}};

    assign resolve_s = brch_instr_detectd_ID && !brch_hazard_stall && rec_valid_r;

    // Compare the carried prediction with the resolved outcome.
    always_comb begin
        mispredict_flush = 1'b0;
        redirect_pc      = {PC_W{1'b0}};
        if (resolve_s) begin
            if (rec_pred_r && !actual_brch_result) begin
                mispredict_flush = 1'b1;
                redirect_pc      = rec_pc_r + PC_W'(32'd4);
            end else if (!rec_pred_r && actual_brch_result) begin
                mispredict_flush = 1'b1;
                redirect_pc      = actual_target;
            end else if (rec_pred_r && actual_brch_result && (rec_tgt_r != actual_target)) begin
                mispredict_flush = 1'b1;
                redirect_pc      = actual_target;
            end else begin
                mispredict_flush = 1'b0;
                redirect_pc      = {PC_W{1'b0}};
            end
        end else begin
            mispredict_flush = 1'b0;
            redirect_pc      = {PC_W{1'b0}};
        end
    end

    // IF/ID prediction record; a flush wins over a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rec_valid_r <= 1'b0;
            rec_pc_r    <= {PC_W{1'b0}};
            rec_idx_r   <= {IDX_W{1'b0}};
            rec_pred_r  <= 1'b0;
            rec_tgt_r   <= {PC_W{1'b0}};
        end else if (mispredict_flush) begin
            rec_valid_r <= 1'b0;
        end else if (!if_stall) begin
            rec_valid_r <= brch_instr_detectd_IF && !mispredict_flush;
            rec_pc_r    <= if_pc;
            rec_idx_r   <= if_idx_s;
            rec_pred_r  <= predict_br_taken;
            rec_tgt_r   <= predict_target;
        end
    end

    // Saturating counts of resolved branches and mispredictions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br_cnt      <= {STAT_W{1'b0}};
            stat_mispred_cnt <= {STAT_W{1'b0}};
        end else begin
            if (resolve_s && (stat_br_cnt != {STAT_W{1'b1}})) begin
                stat_br_cnt <= stat_br_cnt + STAT_W'(1'b1);
            end
            if (mispredict_flush && (stat_mispred_cnt != {STAT_W{1'b1}})) begin
                stat_mispred_cnt <= stat_mispred_cnt + STAT_W'(1'b1);
            end
        end
    end

endmodule

// File: tb/tb_brnch_pred_ctrl.sv
// Directed testbench for brnch_pred_ctrl with hand-computed expectations.
module tb_brnch_pred_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        brch_instr_detectd_IF;
    logic        if_stall;
    logic        brch_instr_detectd_ID;
    logic        brch_hazard_stall;
    logic        actual_brch_result;
    logic [31:0] actual_target;
    logic        predict_br_taken;
    logic [31:0] predict_target;
    logic        mispredict_flush;
    logic [31:0] redirect_pc;
    logic [15:0] stat_br_cnt;
    logic [15:0] stat_mispred_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    brnch_pred_ctrl dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .if_pc                 (if_pc),
        .brch_instr_detectd_IF (brch_instr_detectd_IF),
        .if_stall              (if_stall),
        .brch_instr_detectd_ID (brch_instr_detectd_ID),
        .brch_hazard_stall     (brch_hazard_stall),
        .actual_brch_result    (actual_brch_result),
        .actual_target         (actual_target),
        .predict_br_taken      (predict_br_taken),
        .predict_target        (predict_target),
        .mispredict_flush      (mispredict_flush),
        .redirect_pc           (redirect_pc),
        .stat_br_cnt           (stat_br_cnt),
        .stat_mispred_cnt      (stat_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        if_pc                 = pc;
        brch_instr_detectd_IF = 1'b1;
        brch_instr_detectd_ID = 1'b0;
        brch_hazard_stall     = 1'b0;
        if_stall              = 1'b0;
        #1;
    endtask

    task automatic resolve(input logic act, input logic [31:0] tgt);
        brch_instr_detectd_IF = 1'b0;
        brch_instr_detectd_ID = 1'b1;
        actual_brch_result    = act;
        actual_target         = tgt;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_pc = 32'h0; brch_instr_detectd_IF = 1'b0; if_stall = 1'b0;
        brch_instr_detectd_ID = 1'b0; brch_hazard_stall = 1'b0;
        actual_brch_result = 1'b0; actual_target = 32'h0;
        step(); step();
        rst_n = 1'b1;
        #1;
        n_chk++; if (predict_br_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %0h exp 0", predict_br_taken); end
        n_chk++; if (predict_target !== 32'h0) begin n_fail++; $display("FAIL reset_ptgt: got %0h exp 0", predict_target); end
        n_chk++; if (mispredict_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0h exp 0", mispredict_flush); end
        n_chk++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redir: got %0h exp 0", redirect_pc); end
        n_chk++; if (stat_br_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_br: got %0h exp 0", stat_br_cnt); end
        n_chk++; if (stat_mispred_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_mis: got %0h exp 0", stat_mispred_cnt); end
    endtask

    task automatic test_allocate();
        fetch(32'h40);
        n_chk++; if (predict_br_taken !== 1'b0) begin n_fail++; $display("FAIL alloc_pred0: got %0h exp 0", predict_br_taken); end
        step();
        resolve(1'b1, 32'h80);
        n_chk++; if (mispredict_flush !== 1'b1) begin n_fail++; $display("FAIL alloc_flush: got %0h exp 1", mispredict_flush); end
        n_chk++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL alloc_redir: got %0h exp 80", redirect_pc); end
        step();
        fetch(32'h40);
        n_chk++; if (predict_br_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_pred1: got %0h exp 1", predict_br_taken); end
        n_chk++; if (predict_target !== 32'h80) begin n_fail++; $display("FAIL alloc_ptgt: got %0h exp 80", predict_target); end
        n_chk++; if (stat_br_cnt !== 16'd1) begin n_fail++; $display("FAIL alloc_br: got %0d exp 1", stat_br_cnt); end
        n_chk++; if (stat_mispred_cnt !== 16'd1) begin n_fail++; $display("FAIL alloc_mis: got %0d exp 1", stat_mispred_cnt); end
    endtask

    task automatic test_not_taken();
        fetch(32'h40);
        step();
        resolve(1'b0, 32'h0);
        n_chk++; if (mispredict_flush !== 1'b1) begin n_fail++; $display("FAIL nt_flush1: got %0h exp 1", mispredict_flush); end
        n_chk++; if (redirect_pc !== 32'h44) begin n_fail++; $display("FAIL nt_redir1: got %0h exp 44", redirect_pc); end
        step();
        fetch(32'h40);
        n_chk++; if (predict_br_taken !== 1'b0) begin n_fail++; $display("FAIL nt_pred_after1: got %0h exp 0", predict_br_taken); end
        step();
        resolve(1'b0, 32'h0);
        n_chk++; if (mispredict_flush !== 1'b0) begin n_fail++; $display("FAIL nt_flush2: got %0h exp 0", mispredict_flush); end
        step();
        fetch(32'h40);
        n_chk++; if (predict_br_taken !== 1'b0) begin n_fail++; $display("FAIL nt_pred_after2: got %0h exp 0", predict_br_taken); end
        n_chk++; if (stat_br_cnt !== 16'd3) begin n_fail++; $display("FAIL nt_br: got %0d exp 3", stat_br_cnt); end
        n_chk++; if (stat_mispred_cnt !== 16'd2) begin n_fail++; $display("FAIL nt_mis: got %0d exp 2", stat_mispred_cnt); end
    endtask

    task automatic test_hysteresis();
        fetch(32'h40);
        step();
        resolve(1'b1, 32'h80);
        n_chk++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL hys_redir1: got %0h exp 80", redirect_pc); end
        step();
        fetch(32'h40);
        n_chk++; if (predict_br_taken !== 1'b0) begin n_fail++; $display("FAIL hys_pred_01: got %0h exp 0", predict_br_taken); end
        step();
        resolve(1'b1, 32'h80);
        n_chk++; if (mispredict_flush !== 1'b1) begin n_fail++; $display("FAIL hys_flush2: got %0h exp 1", mispredict_flush); end
        step();
        fetch(32'h40);
        n_chk++; if (predict_br_taken !== 1'b1) begin n_fail++; $display("FAIL hys_pred_11: got %0h exp 1", predict_br_taken); end
        step();
        resolve(1'b0, 32'h0);
        n_chk++; if (redirect_pc !== 32'h44) begin n_fail++; $display("FAIL hys_redir3: got %0h exp 44", redirect_pc); end
        step();
        fetch(32'h40);
        n_chk++; if (predict_br_taken !== 1'b1) begin n_fail++; $display("FAIL hys_pred_10: got %0h exp 1", predict_br_taken); end
        n_chk++; if (predict_target !== 32'h80) begin n_fail++; $display("FAIL hys_ptgt: got %0h exp 80", predict_target); end
        n_chk++; if (stat_mispred_cnt !== 16'd5) begin n_fail++; $display("FAIL hys_mis: got %0d exp 5", stat_mispred_cnt); end
    endtask

    task automatic test_hazard_stall();
        fetch(32'h40);
        step();
        if_stall = 1'b1; brch_instr_detectd_IF = 1'b1; if_pc = 32'h40;
        brch_instr_detectd_ID = 1'b1; brch_hazard_stall = 1'b1;
        actual_brch_result = 1'b0; actual_target = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (mispredict_flush !== 1'b0) begin n_fail++; $display("FAIL hz_flush[%0d]: got %0h exp 0", i, mispredict_flush); end
            n_chk++; if (predict_br_taken !== 1'b1) begin n_fail++; $display("FAIL hz_ctr[%0d]: got %0h exp 1", i, predict_br_taken); end
            n_chk++; if (stat_br_cnt !== 16'd6) begin n_fail++; $display("FAIL hz_br[%0d]: got %0d exp 6", i, stat_br_cnt); end
            step();
        end
        brch_hazard_stall = 1'b0; if_stall = 1'b0; brch_instr_detectd_IF = 1'b0;
        actual_brch_result = 1'b1; actual_target = 32'h80;
        #1;
        n_chk++; if (mispredict_flush !== 1'b0) begin n_fail++; $display("FAIL hz_res_flush: got %0h exp 0", mispredict_flush); end
        step();
        n_chk++; if (stat_br_cnt !== 16'd7) begin n_fail++; $display("FAIL hz_res_br: got %0d exp 7", stat_br_cnt); end
        n_chk++; if (stat_mispred_cnt !== 16'd5) begin n_fail++; $display("FAIL hz_res_mis: got %0d exp 5", stat_mispred_cnt); end
    endtask

    task automatic test_alias();
        fetch(32'h440);
        n_chk++; if (predict_br_taken !== 1'b0) begin n_fail++; $display("FAIL alias_miss: got %0h exp 0", predict_br_taken); end
        step();
        resolve(1'b1, 32'h200);
        n_chk++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL alias_redir: got %0h exp 200", redirect_pc); end
        step();
        fetch(32'h40);
        n_chk++; if (predict_br_taken !== 1'b0) begin n_fail++; $display("FAIL alias_old_pred: got %0h exp 0", predict_br_taken); end
        n_chk++; if (predict_target !== 32'h0) begin n_fail++; $display("FAIL alias_old_ptgt: got %0h exp 0", predict_target); end
        fetch(32'h440);
        n_chk++; if (predict_target !== 32'h200) begin n_fail++; $display("FAIL alias_new_ptgt: got %0h exp 200", predict_target); end
        fetch(32'h40);
        step();
        resolve(1'b1, 32'h80);
        step();
        n_chk++; if (stat_br_cnt !== 16'd9) begin n_fail++; $display("FAIL alias_br: got %0d exp 9", stat_br_cnt); end
    endtask

    task automatic test_target_mismatch();
        fetch(32'h40);
        n_chk++; if (predict_target !== 32'h80) begin n_fail++; $display("FAIL tm_ptgt: got %0h exp 80", predict_target); end
        step();
        resolve(1'b1, 32'h100);
        if_stall = 1'b1; brch_instr_detectd_IF = 1'b1; if_pc = 32'h40;
        #1;
        n_chk++; if (mispredict_flush !== 1'b1) begin n_fail++; $display("FAIL tm_flush: got %0h exp 1", mispredict_flush); end
        n_chk++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL tm_redir: got %0h exp 100", redirect_pc); end
        step();
        if_stall = 1'b0; brch_instr_detectd_IF = 1'b0;
        actual_brch_result = 1'b0; actual_target = 32'h0;
        #1;
        n_chk++; if (mispredict_flush !== 1'b0) begin n_fail++; $display("FAIL tm_rec_cleared: got %0h exp 0", mispredict_flush); end
        step();
        n_chk++; if (stat_br_cnt !== 16'd10) begin n_fail++; $display("FAIL tm_br: got %0d exp 10", stat_br_cnt); end
        fetch(32'h40);
        n_chk++; if (predict_target !== 32'h100) begin n_fail++; $display("FAIL tm_tgt_upd: got %0h exp 100", predict_target); end
    endtask

    task automatic test_reset_mid();
        fetch(32'h40);
        step();
        rst_n = 1'b0;
        resolve(1'b0, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        n_chk++; if (mispredict_flush !== 1'b0) begin n_fail++; $display("FAIL rm_flush: got %0h exp 0", mispredict_flush); end
        n_chk++; if (stat_br_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_br: got %0d exp 0", stat_br_cnt); end
        n_chk++; if (stat_mispred_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_mis: got %0d exp 0", stat_mispred_cnt); end
        fetch(32'h40);
        n_chk++; if (predict_br_taken !== 1'b0) begin n_fail++; $display("FAIL rm_pred: got %0h exp 0", predict_br_taken); end
    endtask

    task automatic test_back_to_back_saturate();
        int flush_seen;
        flush_seen = 0;
        if_pc = 32'h8; brch_instr_detectd_IF = 1'b1; if_stall = 1'b0;
        brch_instr_detectd_ID = 1'b1; brch_hazard_stall = 1'b0;
        actual_brch_result = 1'b0; actual_target = 32'h0;
        #1;
        for (int i = 0; i < 6; i++) step();
        n_chk++; if (stat_br_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_b2b: got %0d exp 5", stat_br_cnt); end
        for (int i = 0; i < 65540; i++) begin
            step();
            if (mispredict_flush !== 1'b0) flush_seen++;
        end
        n_chk++; if (stat_br_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_br: got %0h exp ffff", stat_br_cnt); end
        n_chk++; if (stat_mispred_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_mis: got %0d exp 0", stat_mispred_cnt); end
        n_chk++; if (flush_seen !== 0) begin n_fail++; $display("FAIL sat_noflush: got %0d exp 0", flush_seen); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_not_taken();
        test_hysteresis();
        test_hazard_stall();
        test_alias();
        test_target_mismatch();
        test_reset_mid();
        test_back_to_back_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/brnch_pred_ctrl.md
Name: brnch_pred_ctrl

Overview:
- Branch-prediction controller replacing the single global 2-bit predictor with a direct-mapped branch history/target table.
- Looks up a prediction and target in IF and carries the prediction record from IF to ID.
- Resolves it in ID against the actual outcome, updates the indexed 2-bit counter, and raises a one-cycle flush/redirect on misprediction.
- Also keeps saturating branch and mispredict statistics counters.

Parameters:
- IDX_W, 4, table index width; table has 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- TAG_W, 8, tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- PC_W, 32, program-counter width.
- STAT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- if_pc  in  PC_W  PC of the instruction in IF
- brch_instr_detectd_IF  in  1  IF instruction is a branch
- if_stall  in  1  IF/ID register holds this cycle
- brch_instr_detectd_ID  in  1  ID instruction is a resolving branch
- brch_hazard_stall  in  1  branch operands not ready; no resolution this cycle
- actual_brch_result  in  1  resolved taken (1) / not taken (0)
- actual_target  in  PC_W  resolved taken target
- predict_br_taken  out  1  IF prediction: taken
- predict_target  out  PC_W  IF predicted target (valid when predict_br_taken)
- mispredict_flush  out  1  flush IF/ID and redirect this cycle
- redirect_pc  out  PC_W  corrected fetch PC (valid with mispredict_flush)
- stat_br_cnt  out  STAT_W  resolved branches
- stat_mispred_cnt  out  STAT_W  mispredictions

Behaviour:
- Table entry fields:
  - valid
  - tag[TAG_W]
  - ctr[2]
  - target[PC_W]
- Reset (rst_n low at posedge):
  - all valid=0, all ctr=2'b00.
  - IF/ID record cleared (rec_valid=0).
  - Stat counters = 0.
  - Combinational outputs are 0 while no hit and no record: predict_br_taken=0, mispredict_flush=0, predict_target=0, redirect_pc=0.
  - Reset mid-operation discards any pending record; no update happens.
- IF lookup is combinational, zero latency:
  - hit = valid & tag match at the IF index.
  - predict_br_taken = brch_instr_detectd_IF & hit & ctr[1].
  - predict_target = entry target when predict_br_taken, else 0.
- IF/ID record, loaded at posedge when !if_stall:
  - rec_valid = brch_instr_detectd_IF & !mispredict_flush.
  - rec_pc, rec_idx, rec_pred = predict_br_taken, rec_tgt = predict_target.
- IF/ID record under if_stall: holds.
- IF/ID record under mispredict_flush: cleared, even if if_stall is high.
- Resolve condition: resolve = brch_instr_detectd_ID & !brch_hazard_stall & rec_valid.
  - When brch_hazard_stall is high, nothing changes and the record holds.
- Mispredict, combinational in the resolve cycle; any one of:
  - rec_pred=1 and actual=0: redirect_pc = rec_pc+4.
  - rec_pred=0 and actual=1: redirect_pc = actual_target.
  - rec_pred=1, actual=1, and rec_tgt != actual_target: redirect_pc = actual_target.
  - mispredict_flush is high for exactly the resolve cycle.
- Counter update at posedge on resolve, entry at rec_idx, when the entry is valid with a matching tag:
  - From 11: taken → 11, not taken → 10.
  - From 10: taken → 11, not taken → 00.
  - From 01: taken → 11, not taken → 00.
  - From 00: taken → 01, not taken → 00.
  - On taken, target ← actual_target.
- Allocation on resolve when the entry misses:
  - Taken: write valid=1, new tag, ctr=2'b10, target=actual_target (overwrites).
  - Not taken: no write.
- Same-index lookup and update in one cycle: lookup sees the pre-update entry. No bypass.
- Stat counters:
  - stat_br_cnt +1 on each resolve.
  - stat_mispred_cnt +1 on each mispredict_flush.
  - Both saturate at all-ones (no wrap).

Decomposition:
- Shared package brnch_pred_pkg holds:
  - ctr_t enum: PREDICT_TAKEN_FIRST=2'b11, PREDICT_TAKEN_SECOND=2'b10, PREDICT_NOT_TAKEN_FIRST=2'b00, PREDICT_NOT_TAKEN_SECOND=2'b01.
  - bht_entry_t struct.
  - A next_ctr() function holding the transition table above.
- One sub-module, bht_table:
  - Register array with 1 combinational read port and 1 synchronous write port.
  - Synchronous clear of valid and ctr on reset.

Test Plan:
1. Reset, then a branch at pc=0x40 in IF: predict_br_taken=0. Resolve taken, target 0x80: mispredict_flush=1, redirect_pc=0x80, entry idx 0 allocated with ctr=10. Next IF at 0x40: predict_br_taken=1, predict_target=0x80.
2. Same branch resolved not taken twice: ctr 10→00; first resolve gives flush with redirect_pc=0x44; next IF prediction=0.
3. Hysteresis: from ctr=00, resolve taken → 01 (prediction still 0); taken again → 11; one not-taken → 10 (prediction still 1).
4. brch_hazard_stall=1 for 3 cycles with brch_instr_detectd_ID=1: no flush, no counter change, stats unchanged; resolves on the 4th cycle.
5. Alias: pc 0x40 and 0x440 share an index with different tags. 0x440 taken overwrites the entry; the 0x40 lookup then misses (prediction 0).
6. Target mismatch: predicted taken to 0x80, resolved taken to 0x100 → flush, redirect_pc=0x100, target updated. Drive 2**STAT_W+5 resolves: stat_br_cnt stays at 0xFFFF.
